// File: rtl/rgb666_pix_pack_if.sv
// Pixel-packer bus: serial RGB666 sink side plus packed Avalon-ST source side.
// Ports: sink_{valid,ready,sop,eop,data}, source_{valid,ready,sop,eop,empty,data}.
interface rgb666_pix_pack_if #(
    parameter int PIX_W   = 18,
    parameter int DATA_W  = 96,
    parameter int EMPTY_W = 4
);
    logic               sink_ready;
    logic               sink_valid;
    logic               sink_sop;
    logic               sink_eop;
    logic [PIX_W-1:0]   sink_data;
    logic               source_ready;
    logic               source_valid;
    logic               source_sop;
    logic               source_eop;
    logic [EMPTY_W-1:0] source_empty;
    logic [DATA_W-1:0]  source_data;

    // master: pixel producer and beat consumer around the packer
    modport master (
        output sink_valid, sink_sop, sink_eop, sink_data, source_ready,
        input  sink_ready, source_valid, source_sop, source_eop,
        input  source_empty, source_data
    );

    // slave: the packer itself
    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_data, source_ready,
        output sink_ready, source_valid, source_sop, source_eop,
        output source_empty, source_data
    );
endinterface

// File: rtl/rgb666_pix_pack.sv
// Packs 1 px/beat RGB666 into 4 px/beat Avalon-ST with sop/eop/empty.
// Ports: clk, reset_n (async, active low), bus (rgb666_pix_pack_if.slave).
// Pixel k of a beat sits at data[18k+17:18k]; bits above the 4 pixels read 0.
// Optional macro PIX_PACK_RESYNC_EN: a sop arriving mid-packet flushes the
// partial beat (eop=1) and starts a new packet with that pixel.
module rgb666_pix_pack #(
    parameter int PIX_W   = 18,
    parameter int N_PIX   = 4,
    parameter int EMPTY_W = 4,
    parameter int DATA_W  = 96
) (
    input logic               clk,
    input logic               reset_n,
    rgb666_pix_pack_if.slave  bus
);
    localparam int CNT_W = $clog2(N_PIX);

    typedef enum logic {IDLE, PKT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              first_beat;
    logic [DATA_W-1:0] acc;

    logic              accept;
    logic              start;
    logic              take;
    logic              flush;
    logic              last;
    logic              emit;
    logic [CNT_W-1:0]  slot;
    logic [DATA_W-1:0] merged;

    // Output register free or draining this cycle; held low in reset.
    assign bus.sink_ready = reset_n & (!bus.source_valid | bus.source_ready);
    assign accept = bus.sink_valid & bus.sink_ready;

`ifdef PIX_PACK_RESYNC_EN
    assign start = accept & bus.sink_sop;
    assign flush = accept & bus.sink_sop & (state == PKT) & (cnt != '0);
`else
    assign start = accept & bus.sink_sop & (state == IDLE);
    assign flush = 1'b0;
`endif

    // In IDLE only a sop pixel is taken; anything else is dropped.
    assign take = start | (accept & (state == PKT));
    assign slot = start ? '0 : cnt;
    assign last = bus.sink_eop | (slot == CNT_W'(N_PIX - 1));
    // A flush occupies the output register, so the new pixel just lands in
    // slot 0; an eop on that same pixel cannot produce a second beat.
    assign emit = take & last & !flush;

    always_comb begin
        merged = start ? '0 : acc;
        merged[int'(slot)*PIX_W +: PIX_W] = bus.sink_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            first_beat       <= 1'b0;
            acc              <= '0;
            bus.source_valid <= 1'b0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
            bus.source_empty <= '0;
            bus.source_data  <= '0;
        end else begin
            if (bus.source_valid && bus.source_ready)
                bus.source_valid <= 1'b0;

            if (flush) begin
                bus.source_valid <= 1'b1;
                bus.source_sop   <= first_beat;
                bus.source_eop   <= 1'b1;
                bus.source_empty <= EMPTY_W'(N_PIX) - EMPTY_W'(cnt);
                bus.source_data  <= acc;
            end else if (emit) begin
                bus.source_valid <= 1'b1;
                bus.source_sop   <= first_beat | start;
                bus.source_eop   <= bus.sink_eop;
                bus.source_empty <= bus.sink_eop
                                  ? EMPTY_W'(N_PIX - 1) - EMPTY_W'(slot)
                                  : '0;
                bus.source_data  <= merged;
            end

            if (take) begin
                if (emit) begin
                    acc        <= '0;
                    cnt        <= '0;
                    first_beat <= 1'b0;
                    state      <= bus.sink_eop ? IDLE : PKT;
                end else begin
                    acc        <= merged;
                    cnt        <= slot + 1'b1;
                    first_beat <= first_beat | start;
                    state      <= PKT;
                end
            end
        end
    end
endmodule
